// File: rtl/sum_pkg.sv
// Shared definitions for the sum-of-1..N unit and its job dispatcher.
// Holds the FSM state encoding, the default operand/result widths and a counter sizing helper.
package sum_pkg;

    localparam int unsigned SUM_N_W   = 8;
    localparam int unsigned SUM_SUM_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StHold  = 2'd3
    } sum_state_e;

    // One extra bit over the larger limit so a counter never wraps at its terminal value.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sum_job_dispatcher_if.sv
// Signal bundle between the dispatcher, its requester, the sum unit and the result consumer.
// The master modport is the dispatcher's view; slave is the surrounding environment.
interface sum_job_dispatcher_if
    import sum_pkg::*;
#(
    parameter int unsigned N_W   = SUM_N_W,
    parameter int unsigned SUM_W = SUM_SUM_W
);
    logic             req_valid;
    logic             req_ready;
    logic [N_W-1:0]   req_n;
    logic             sum_start;
    logic [N_W-1:0]   sum_n;
    logic             sum_done;
    logic [SUM_W-1:0] sum_result;
    logic             res_valid;
    logic             res_ready;
    logic [N_W-1:0]   res_n;
    logic [SUM_W-1:0] res_sum;
    logic             res_err;
    logic             busy;

    modport master (
        input  req_valid, req_n, sum_done, sum_result, res_ready,
        output req_ready, sum_start, sum_n, res_valid, res_n, res_sum, res_err, busy
    );

    modport slave (
        output req_valid, req_n, sum_done, sum_result, res_ready,
        input  req_ready, sum_start, sum_n, res_valid, res_n, res_sum, res_err, busy
    );

endinterface

// File: rtl/sum_req_fifo.sv
// Request FIFO for the dispatcher: power-of-2 depth, synchronous reset, full/empty from count.
// Pushes while full and pops while empty are dropped internally.
module sum_req_fifo #(
    parameter int unsigned  DEPTH = 4,
    parameter int unsigned  WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sum_job_dispatcher.sv
// Feeds queued N values to the sum unit with a start pulse, waits for done or a watchdog timeout,
// and holds each result in a valid/ready output stage until the consumer takes it.
module sum_job_dispatcher
    import sum_pkg::*;
#(
    parameter int unsigned N_W         = SUM_N_W,
    parameter int unsigned SUM_W       = SUM_SUM_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned START_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic                  clk,
    input logic                  rst,
    sum_job_dispatcher_if.master bus
);

    localparam int unsigned     CNT_W      = cnt_width(START_CYC, TIMEOUT_CYC);
    localparam int unsigned     FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    sum_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sum_start_q;
    logic [N_W-1:0]   sum_n_q;
    logic             res_valid_q;
    logic [N_W-1:0]   res_n_q;
    logic [SUM_W-1:0] res_sum_q;
    logic             res_err_q;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [N_W-1:0]   fifo_head;
    logic [FIFO_AW:0] fifo_count;

    sum_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (N_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req_valid),
        .pop   (fifo_pop),
        .wdata (bus.req_n),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_pop      = (state_q == StIdle) && !fifo_empty;
    assign bus.req_ready = !fifo_full;
    assign bus.sum_start = sum_start_q;
    assign bus.sum_n     = sum_n_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_n     = res_n_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = (state_q != StIdle) || (fifo_count != '0);

    // sum_n only reloads in IDLE, so it is frozen for the whole START/WAIT span of a job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sum_start_q <= 1'b0;
            sum_n_q     <= '0;
            res_valid_q <= 1'b0;
            res_n_q     <= '0;
            res_sum_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        sum_n_q     <= fifo_head;
                        cnt_q       <= '0;
                        sum_start_q <= 1'b1;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == START_LAST) begin
                        cnt_q       <= '0;
                        sum_start_q <= 1'b0;
                        state_q     <= StWait;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StWait: begin
                    // A done pulse on the final watchdog cycle still counts as a completion.
                    if (bus.sum_done) begin
                        res_sum_q   <= bus.sum_result;
                        res_n_q     <= sum_n_q;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end else if (cnt_q == WDOG_LAST) begin
                        res_sum_q   <= '0;
                        res_n_q     <= sum_n_q;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StHold: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_job_dispatcher.sv
// Self-checking bench for sum_job_dispatcher: a behavioural sum unit answers each job and a
// scoreboard of expected results is compared in order against the result stage.
module tb_sum_job_dispatcher;

    localparam int unsigned N_W     = 8;
    localparam int unsigned SUM_W   = 16;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [N_W-1:0]   n;
        logic [SUM_W-1:0] sum;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sum_job_dispatcher_if #(.N_W(N_W), .SUM_W(SUM_W)) bus ();

    sum_job_dispatcher #(
        .N_W         (N_W),
        .SUM_W       (SUM_W),
        .FIFO_DEPTH  (4),
        .START_CYC   (2),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural sum unit plus a manual override used to inject stray done pulses.
    bit               unit_en    = 1'b1;
    int               unit_delay = 8;
    bit               armed      = 1'b0;
    int               ucnt       = 0;
    logic             prev_start = 1'b0;
    logic [N_W-1:0]   latched_n  = '0;
    logic             model_done = 1'b0;
    logic [SUM_W-1:0] model_result = '0;
    logic             man_done   = 1'b0;
    logic [SUM_W-1:0] man_result = '0;

    assign bus.sum_done   = model_done | man_done;
    assign bus.sum_result = man_done ? man_result : model_result;

    function automatic logic [SUM_W-1:0] tri_sum(input logic [N_W-1:0] n);
        return SUM_W'((32'(n) * (32'(n) + 32'd1)) / 32'd2);
    endfunction

    always @(negedge clk) begin
        model_done = 1'b0;
        if (rst) begin
            armed      = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (armed) begin
                ucnt++;
                if (ucnt == unit_delay) begin
                    model_done   = 1'b1;
                    model_result = tri_sum(latched_n);
                    armed        = 1'b0;
                end
            end
            if (prev_start && !bus.sum_start && unit_en) begin
                armed     = 1'b1;
                ucnt      = 0;
                latched_n = bus.sum_n;
            end
            prev_start = bus.sum_start;
        end
    end

    // Drives one request cycle; caller deasserts req_valid when the burst ends.
    task automatic push_req(input logic [N_W-1:0] n, input logic err_exp, output bit accepted);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_n     = n;
        accepted      = bus.req_ready;
        if (accepted) begin
            e.n   = n;
            e.sum = err_exp ? '0 : tri_sum(n);
            e.err = err_exp;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_n     = '0;
        bus.res_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.sum_start, bus.sum_n, bus.res_valid, bus.res_n, bus.res_sum, bus.res_err,
             bus.busy, bus.req_ready} !== {1'b0, 8'd0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1})
            begin
            errors++;
            $display("FAIL reset_state: got start=%b n=%0d rv=%b rn=%0d rs=%0d re=%b busy=%b rdy=%b expected zeros with rdy=1",
                     bus.sum_start, bus.sum_n, bus.res_valid, bus.res_n, bus.res_sum,
                     bus.res_err, bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_single();
        bit   acc;
        exp_t e;
        int   starts = 0;
        int   first_start = -1;
        int   fv = -1;
        bus.res_ready = 1'b1;
        push_req(8'd4, 1'b0, acc);
        bus.req_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL single_accept: got req_ready=0 expected 1");
        end
        for (int i = 0; i < 60; i++) begin
            if (bus.sum_start === 1'b1) begin
                starts++;
                if (first_start < 0) first_start = i;
            end
            if (bus.res_valid === 1'b1) begin
                fv = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (starts != 2 || first_start != 1) begin
            errors++;
            $display("FAIL single_start: got %0d high cycles from %0d expected 2 from 1",
                     starts, first_start);
        end
        checks++;
        if (fv != 12) begin
            errors++;
            $display("FAIL single_latency: got res_valid at %0d expected 12", fv);
        end
        if (fv >= 0 && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({bus.res_n, bus.res_sum, bus.res_err} !== {e.n, e.sum, e.err}) begin
                errors++;
                $display("FAIL single_result: got n=%0d sum=%0d err=%b expected n=%0d sum=%0d err=%b",
                         bus.res_n, bus.res_sum, bus.res_err, e.n, e.sum, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_burst();
        bit             acc;
        exp_t           e;
        int             got = 0;
        logic [N_W-1:0] ns [6] = '{8'd10, 8'd255, 8'd1, 8'd3, 8'd7, 8'd9};
        bus.res_ready = 1'b1;
        // First job leaves the FIFO at once, so the fifth push fills it and the sixth is refused.
        for (int i = 0; i < 6; i++) begin
            push_req(ns[i], 1'b0, acc);
            checks++;
            if (acc !== (i < 5)) begin
                errors++;
                $display("FAIL burst_accept[%0d]: got req_ready=%b expected %b", i, acc, i < 5);
            end
        end
        bus.req_valid = 1'b0;
        for (int c = 0; c < 400 && got < 5; c++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL burst_result: got unexpected n=%0d expected none", bus.res_n);
                end else begin
                    e = sb.pop_front();
                    if ({bus.res_n, bus.res_sum, bus.res_err} !== {e.n, e.sum, e.err}) begin
                        errors++;
                        $display("FAIL burst_result: got n=%0d sum=%0d err=%b expected n=%0d sum=%0d err=%b",
                                 bus.res_n, bus.res_sum, bus.res_err, e.n, e.sum, e.err);
                    end
                end
            end
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL burst_count: got %0d results expected 5", got);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit   acc;
        exp_t e;
        int   got = 0;
        bus.res_ready = 1'b0;
        push_req(8'd5, 1'b0, acc);
        bus.req_valid = 1'b0;
        for (int c = 0; c < 100 && bus.res_valid !== 1'b1; c++) @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid: got res_valid=%b expected 1", bus.res_valid);
        end
        e = (sb.size() != 0) ? sb[0] : '0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({bus.res_valid, bus.res_n, bus.res_sum, bus.res_err} !==
                {1'b1, e.n, e.sum, e.err} || bus.sum_start !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rv=%b n=%0d sum=%0d err=%b start=%b expected rv=1 n=%0d sum=%0d err=%b start=0",
                         i, bus.res_valid, bus.res_n, bus.res_sum, bus.res_err, bus.sum_start,
                         e.n, e.sum, e.err);
            end
            if (i < 5) begin
                push_req(8'(20 + i), 1'b0, acc);
                checks++;
                if (acc !== (i < 4)) begin
                    errors++;
                    $display("FAIL bp_accept[%0d]: got req_ready=%b expected %b", i, acc, i < 4);
                end
            end else begin
                bus.req_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.res_ready = 1'b1;
        if (sb.size() != 0) e = sb.pop_front();
        for (int c = 0; c < 300 && got < 4; c++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL bp_result: got unexpected n=%0d expected none", bus.res_n);
                end else begin
                    e = sb.pop_front();
                    if ({bus.res_n, bus.res_sum, bus.res_err} !== {e.n, e.sum, e.err}) begin
                        errors++;
                        $display("FAIL bp_result: got n=%0d sum=%0d err=%b expected n=%0d sum=%0d err=%b",
                                 bus.res_n, bus.res_sum, bus.res_err, e.n, e.sum, e.err);
                    end
                end
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d results expected 4", got);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit   acc;
        exp_t e;
        int   fv = -1;
        unit_en       = 1'b0;
        bus.res_ready = 1'b0;
        push_req(8'd9, 1'b1, acc);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.res_valid === 1'b1) begin
                fv = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (fv != 19) begin
            errors++;
            $display("FAIL timeout_latency: got res_valid at %0d expected 19", fv);
        end
        e = (sb.size() != 0) ? sb[0] : '0;
        checks++;
        if ({bus.res_n, bus.res_sum, bus.res_err} !== {e.n, e.sum, e.err}) begin
            errors++;
            $display("FAIL timeout_result: got n=%0d sum=%0d err=%b expected n=%0d sum=%0d err=%b",
                     bus.res_n, bus.res_sum, bus.res_err, e.n, e.sum, e.err);
        end
        man_result = 16'h0777;
        man_done   = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.res_valid, bus.res_n, bus.res_sum, bus.res_err} !== {1'b1, e.n, e.sum, e.err})
            begin
            errors++;
            $display("FAIL late_done: got rv=%b n=%0d sum=%0d err=%b expected rv=1 n=%0d sum=%0d err=%b",
                     bus.res_valid, bus.res_n, bus.res_sum, bus.res_err, e.n, e.sum, e.err);
        end
        bus.res_ready = 1'b1;
        if (sb.size() != 0) e = sb.pop_front();
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: got res_valid=%b expected 0", bus.res_valid);
        end
        unit_en = 1'b1;
    endtask

    task automatic test_collide();
        bit   acc;
        exp_t e;
        int   fv = -1;
        unit_delay    = int'(TIMEOUT) - 1;
        bus.res_ready = 1'b1;
        push_req(8'd6, 1'b0, acc);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.res_valid === 1'b1) begin
                fv = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (fv != 19) begin
            errors++;
            $display("FAIL collide_latency: got res_valid at %0d expected 19", fv);
        end
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        checks++;
        if ({bus.res_n, bus.res_sum, bus.res_err} !== {e.n, e.sum, e.err}) begin
            errors++;
            $display("FAIL collide_result: got n=%0d sum=%0d err=%b expected n=%0d sum=%0d err=%b",
                     bus.res_n, bus.res_sum, bus.res_err, e.n, e.sum, e.err);
        end
        unit_delay = 8;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        bit acc;
        int stray = 0;
        bus.res_ready = 1'b1;
        push_req(8'd4, 1'b0, acc);
        push_req(8'd5, 1'b0, acc);
        push_req(8'd6, 1'b0, acc);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        checks++;
        if ({bus.sum_start, bus.busy, bus.res_valid, bus.res_sum} !== {1'b0, 1'b0, 1'b0, 16'd0})
            begin
            errors++;
            $display("FAIL rst_mid: got start=%b busy=%b rv=%b sum=%0d expected 0 0 0 0",
                     bus.sum_start, bus.busy, bus.res_valid, bus.res_sum);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || bus.sum_start !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_flush: got %0d active cycles after reset expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_timeout();
        test_collide();
        test_reset_mid_job();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1, "bench timed out");
    end

endmodule
